// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the mips_alu execute-stage ALU.
//   ALU_WIDTH : default operand/result width
//   ALU_*     : 4-bit operation select codes driven by the control decoder
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XNOR = 4'b1100;

endpackage

// File: rtl/mips_alu_if.sv
// mips_alu_if: operand/result bundle between the execute stage and the ALU.
//   a, b      : operands (two's complement)
//   alu_ctrl  : operation select
//   res       : registered result
//   zero      : registered res == 0
//   carry_out : registered unsigned carry of the adder
//   overflow  : registered signed overflow
// Modports: master drives operands and reads results; slave is the ALU.
interface mips_alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             carry_out;
    logic             overflow;

    modport master (
        output a, b, alu_ctrl,
        input  res, zero, carry_out, overflow
    );

    modport slave (
        input  a, b, alu_ctrl,
        output res, zero, carry_out, overflow
    );
endinterface

// File: rtl/alu_addsub.sv
// alu_addsub: combinational adder/subtractor shared by ADD, SUB and SLT.
//   a, b  : operands
//   sub   : 0 = a + b, 1 = a + ~b + 1
//   sum   : WIDTH-bit result (wraps)
//   carry : bit WIDTH of the unsigned sum (for SUB, 1 = no borrow)
//   ovf   : signed overflow of the operation
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum   = full[WIDTH-1:0];
    assign carry = full[WIDTH];
    // Overflow when the effective addends share a sign and the sum's sign differs;
    // with b inverted this covers the subtract case too.
    assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/mips_alu.sv
// mips_alu: 32-bit MIPS-style ALU with one-cycle registered result and flags.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (res=0, zero=1, carry_out=0, overflow=0)
//   bus   : mips_alu_if slave (a, b, alu_ctrl in; res, zero, carry_out, overflow out)
module mips_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    mips_alu_if.slave   bus
);
    logic             use_sub;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;

    logic [WIDTH-1:0] res_nxt;
    logic             carry_nxt;
    logic             ovf_nxt;

    assign use_sub = (bus.alu_ctrl == ALU_SUB) || (bus.alu_ctrl == ALU_SLT);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a     (bus.a),
        .b     (bus.b),
        .sub   (use_sub),
        .sum   (as_sum),
        .carry (as_carry),
        .ovf   (as_ovf)
    );

    always_comb begin
        res_nxt   = '0;
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
        case (bus.alu_ctrl)
            ALU_AND:  res_nxt = bus.a & bus.b;
            ALU_OR:   res_nxt = bus.a | bus.b;
            ALU_ADD, ALU_SUB: begin
                res_nxt   = as_sum;
                carry_nxt = as_carry;
                ovf_nxt   = as_ovf;
            end
            // Signed less-than stays correct when the difference overflows.
            ALU_SLT:  res_nxt = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
            ALU_XNOR: res_nxt = ~(bus.a ^ bus.b);
            default:  res_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res       <= '0;
            bus.zero      <= 1'b1;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.res       <= res_nxt;
            bus.zero      <= (res_nxt == '0);
            bus.carry_out <= carry_nxt;
            bus.overflow  <= ovf_nxt;
        end
    end
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed plus randomized checks of mips_alu against an
// arithmetic reference model.
module tb_mips_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    mips_alu_if #(.WIDTH(32)) bus ();

    mips_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model computed with wide signed/unsigned arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c, output logic v);
        longint sa, sb, sr;
        longint unsigned ua, ub, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                ur = ua + ub;
                sr = sa + sb;
                r  = ur[31:0];
                c  = (ur > 64'hFFFF_FFFF);
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0110: begin
                sr = sa - sb;
                r  = a - b;
                c  = (ua >= ub);
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a ^ b);
            default: r = 32'd0;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic ec, ev;
        @(negedge clk);
        bus.alu_ctrl = op;
        bus.a        = a;
        bus.b        = b;
        model(op, a, b, er, ec, ev);
        @(posedge clk);
        #1;
        check({tag, ".res"},  bus.res,              er);
        check({tag, ".zero"}, {31'd0, bus.zero},      {31'd0, er == 32'd0});
        check({tag, ".cout"}, {31'd0, bus.carry_out}, {31'd0, ec});
        check({tag, ".ovf"},  {31'd0, bus.overflow},  {31'd0, ev});
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".res"},  bus.res,                32'd0);
        check({tag, ".zero"}, {31'd0, bus.zero},      32'd1);
        check({tag, ".cout"}, {31'd0, bus.carry_out}, 32'd0);
        check({tag, ".ovf"},  {31'd0, bus.overflow},  32'd0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'd0;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; } vec_t;

    initial begin
        vec_t dir[$];
        logic [3:0] ops[8];
        n_checks = 0;
        n_pass   = 0;
        rst_n        = 1'b0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.alu_ctrl = ALU_ADD;

        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Load non-reset values, then drop reset mid-cycle.
        run_op("pre", ALU_XNOR, 32'd1, 32'd2);
        run_op("pre2", ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Direct constant checks for key plan values.
        run_op("and_neg", ALU_AND, -32'sd20, 32'd10);
        check("and_neg.const", bus.res, 32'd8);
        run_op("slt_ovf", ALU_SLT, 32'h8000_0000, 32'd1);
        check("slt_ovf.const", bus.res, 32'd1);
        run_op("sub_ovf", ALU_SUB, 32'h8000_0000, 32'd1);
        check("sub_ovf.const", bus.res, 32'h7FFF_FFFF);
        check("sub_ovf.vconst", {31'd0, bus.overflow}, 32'd1);

        dir.push_back('{ALU_AND,  32'd7,      32'd5});
        dir.push_back('{ALU_OR,   32'd10,     32'd40});
        dir.push_back('{ALU_OR,   32'd9,      32'd5});
        dir.push_back('{ALU_ADD,  32'd9,      32'd5});
        dir.push_back('{ALU_ADD,  32'd256,    32'd256});
        dir.push_back('{ALU_ADD,  32'd32768,  32'd512});
        dir.push_back('{ALU_ADD,  32'd8902,   32'd0});
        dir.push_back('{ALU_ADD,  32'd0,      32'd4750});
        dir.push_back('{ALU_SUB,  32'd0,      32'd4750});
        dir.push_back('{ALU_SLT,  32'd0,      32'd4750});
        dir.push_back('{ALU_XNOR, 32'd0,      32'd4750});
        dir.push_back('{ALU_ADD,  32'h7FFF_FFFF, 32'd1});
        dir.push_back('{ALU_ADD,  32'h7FFF_FFFF, 32'h8000_0001});
        dir.push_back('{ALU_SUB,  -32'sd50,   -32'sd50});
        dir.push_back('{4'b1111,  32'd123,    32'd456});
        dir.push_back('{ALU_SLT,  -32'sd10,   32'd20});
        dir.push_back('{ALU_SLT,  32'd10,     32'd12});
        dir.push_back('{ALU_SLT,  32'd12,     32'd10});
        dir.push_back('{ALU_SLT,  -32'sd12,   -32'sd14});
        foreach (dir[i]) run_op($sformatf("dir%0d", i), dir[i].op, dir[i].a, dir[i].b);

        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_XNOR, 4'b0011, 4'b1010};
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
            else op = ops[$urandom_range(0, 7)];
            run_op($sformatf("rnd%0d", i), op, pick_val(), pick_val());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit MIPS-style arithmetic/logic unit with registered result and status flags.
- Performs AND, OR, ADD, SUB, SLT and XNOR on two signed operands, selected by a 4-bit control code from the datapath control decoder.
- Sits in the execute stage. Operands are sampled combinationally and the result plus flags are registered, with one-cycle latency.

Parameters:
- WIDTH, 32, operand/result width in bits (all rules below are written for WIDTH=32).

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- a  in  WIDTH  operand A, two's complement.
- b  in  WIDTH  operand B, two's complement.
- alu_ctrl  in  4  operation select.
- res  out  WIDTH  registered result.
- zero  out  1  registered flag: res == 0.
- carry_out  out  1  registered unsigned carry out of the adder.
- overflow  out  1  registered signed-overflow flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n=0, outputs are forced immediately, independent of clk: res=0, zero=1, carry_out=0, overflow=0. Reset has priority over any pending operation; the first operation is captured on the first rising clk edge after rst_n deasserts.
- Latency: the result for (a, b, alu_ctrl) present before rising edge N appears on the outputs after edge N and holds until the next edge. No handshake: an operation is issued every cycle.
- Opcodes:
  - 0000 AND: res = a & b.
  - 0001 OR: res = a | b.
  - 0010 ADD: res = a + b (mod 2^32).
  - 0110 SUB: res = a + ~b + 1 (mod 2^32).
  - 0111 SLT: res = 1 if a < b as signed, else 0. Compute from the subtractor as sign(diff) XOR overflow(diff) so the result is correct when the subtraction overflows.
  - 1100 XNOR: res = ~(a ^ b).
  - All other codes: res = 0, carry_out = 0, overflow = 0.
- ADD flags:
  - carry_out = bit 32 of the 33-bit unsigned sum.
  - overflow = 1 when a and b have equal signs and the result sign differs.
- SUB flags:
  - carry_out = bit 32 of a + ~b + 1, so 1 means no borrow (a >= b unsigned).
  - overflow = 1 when a and b have different signs and the result sign differs from a.
- Logic ops and SLT: carry_out = 0, overflow = 0.
- zero is derived from the registered res value for every opcode, including undefined codes (which give zero=1).
- Wrap-around: ADD and SUB wrap modulo 2^32 and never saturate.

Decomposition:
- Package alu_pkg holds:
  - the opcode localparams ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_XNOR;
  - the WIDTH default.
- One combinational sub-module, alu_addsub (inputs a, b, sub; outputs sum, carry, ovf), shared by ADD, SUB and SLT.
- The top level contains the op mux and the output register stage.

Test Plan:
- Reset and logic ops:
  - Assert rst_n=0 mid-cycle -> res=0, zero=1, carry_out=0, overflow=0 immediately.
  - After release, AND a=-20, b=10 -> res=8.
  - AND 7,5 -> 5.
  - OR 10,40 -> 42.
  - OR 9,5 -> 13.
  - Each result appears one clk later.
- ADD:
  - 9+5 -> 14.
  - 256+256 -> 512.
  - 32768+512 -> 33280.
  - 8902+0 -> 8902.
  - 0+4750 -> 4750.
  - All with overflow=0 and carry_out=0.
- SUB/SLT/XNOR with a=0, b=4750:
  - SUB -> res=-4750, carry_out=0, overflow=0.
  - SLT -> 1.
  - XNOR -> -4751.
- Overflow:
  - ADD 2147483647+1 -> res=-2147483648, overflow=1, carry_out=0.
  - SUB -2147483648-1 -> res=2147483647, overflow=1, carry_out=1.
- Zero flag:
  - ADD 2147483647 + (-2147483647) -> res=0, zero=1, carry_out=1.
  - SUB -50 - (-50) -> res=0, zero=1, carry_out=1.
  - Undefined opcode 1111 -> res=0, zero=1.
- SLT signed:
  - (-10,20) -> 1.
  - (10,12) -> 1.
  - (12,10) -> 0, zero=1.
  - (-12,-14) -> 0.
  - (-2147483648, 1) -> 1 despite subtraction overflow.
